mult_sched: RTL and testbench

//  Round-robin scheduler that shares one pipelined 4x4 unsigned multiplier between N_REQ requesters.

---
 rtl/mult_sched_pkg.sv | 22 ++
 rtl/mult_sched_tagpipe.sv | 39 +++
 rtl/mult_sched.sv | 181 ++++++++++++++++++
 tb/tb_mult_sched.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_sched_pkg.sv
// Shared types and widths for the multiplier scheduler.
//   A_W/B_W/P_W : operand and product widths of the shared 4x4 multiplier
//   state_e     : scheduler mode, RUN grants requests, DRAIN only empties the pipe
//   tag_t       : in-flight op tag {vld, id}; id is sized for up to 8 requesters
package mult_sched_pkg;

  localparam int unsigned A_W  = 4;
  localparam int unsigned B_W  = 4;
  localparam int unsigned P_W  = 8;
  localparam int unsigned ID_W = 3;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/mult_sched_tagpipe.sv
// Tag delay line that follows ops through the multiplier pipeline.
//   clk, rst : clock, synchronous active-high reset (clears all stages)
//   ena      : advance enable; 0 holds every stage
//   d        : tag entering the pipe
//   q        : tag leaving the pipe, DEPTH enabled edges after entry
module mult_sched_tagpipe #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] pipe_q [DEPTH];
  logic [W-1:0] pipe_d [DEPTH];

  // Shift by one stage when enabled, otherwise hold.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) pipe_d[i] = pipe_q[i];
    if (ena) begin
      pipe_d[0] = d;
      for (int unsigned i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign q = pipe_q[DEPTH-1];

endmodule

// File: rtl/mult_sched.sv
// Scheduler sharing one pipelined 4x4 multiplier among N_REQ requesters.
// Grants at most one valid/ready transfer per cycle, tags each op, and
// returns the product to its owner as a one-cycle rsp_valid pulse.
//   clk, rst            : clock, synchronous active-high reset
//   ena                 : global enable, 0 freezes everything
//   req_valid/a/b       : per-requester operands (4 bits each, packed)
//   req_ready           : one-hot grant, combinational from req_valid
//   flush / flush_done  : stop granting and drain; done when pipe empty
//   mul_a/mul_b/mul_ena : registered operands and enable to the multiplier
//   mul_product         : multiplier result
//   rsp_valid/rsp_data  : registered one-hot owner and product
//   busy                : issue register or tag pipe holds an op
// Build option: MULT_SCHED_FIXED_PRIO_EN selects fixed priority (lowest
// index wins, no round-robin pointer); default is round-robin.
module mult_sched
  import mult_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned LAT   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [A_W*N_REQ-1:0] req_a,
  input  logic [B_W*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]     req_ready,
  input  logic                 flush,
  output logic                 flush_done,
  output logic [A_W-1:0]       mul_a,
  output logic [B_W-1:0]       mul_b,
  output logic                 mul_ena,
  input  logic [P_W-1:0]       mul_product,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [P_W-1:0]       rsp_data,
  output logic                 busy
);

  localparam int unsigned IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // The multiplier registers its operands before its LAT-stage pipeline,
  // so the tag needs one extra stage to leave together with the product.
  localparam int unsigned TDEPTH = LAT + 1;
  localparam int unsigned CNT_W  = $clog2(TDEPTH + 1);

  state_e             state_q, state_d;
  tag_t               issue_q, issue_d;
  tag_t               tag_out;
  logic [A_W-1:0]     mul_a_q, mul_a_d;
  logic [B_W-1:0]     mul_b_q, mul_b_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [P_W-1:0]     rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;

  logic               grant_en_c, gnt_vld_c, grant_c;
  logic [IDW-1:0]     gnt_idx_c;
  logic [A_W-1:0]     sel_a_c;
  logic [B_W-1:0]     sel_b_c;

`ifdef MULT_SCHED_FIXED_PRIO_EN
`else
  logic [IDW-1:0]     rr_q, rr_d;
  int unsigned        idx;
`endif

  // Arbiter: pick the winning requester and its operands.
  always_comb begin
    gnt_vld_c  = 1'b0;
    gnt_idx_c  = '0;
    sel_a_c    = '0;
    sel_b_c    = '0;
    grant_en_c = ena && !rst && !flush && (state_q == RUN);
`ifdef MULT_SCHED_FIXED_PRIO_EN
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!gnt_vld_c && req_valid[IDW'(k)]) begin
        gnt_vld_c = 1'b1;
        gnt_idx_c = IDW'(k);
      end
    end
`else
    idx = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(rr_q) + k) % N_REQ;
      if (!gnt_vld_c && req_valid[IDW'(idx)]) begin
        gnt_vld_c = 1'b1;
        gnt_idx_c = IDW'(idx);
      end
    end
`endif
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_idx_c == IDW'(i)) begin
        sel_a_c = req_a[i*A_W +: A_W];
        sel_b_c = req_b[i*B_W +: B_W];
      end
    end
    grant_c   = grant_en_c && gnt_vld_c;
    req_ready = grant_c ? (N_REQ'(1) << gnt_idx_c) : '0;
  end

  // Next-state logic; everything holds while ena is low.
  always_comb begin
    state_d     = state_q;
    issue_d     = issue_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    inflight_d  = inflight_q;
`ifdef MULT_SCHED_FIXED_PRIO_EN
`else
    rr_d        = rr_q;
`endif
    if (ena) begin
      case (state_q)
        RUN:   if (flush)  state_d = DRAIN;
        DRAIN: if (!flush) state_d = RUN;
      endcase
      issue_d.vld = grant_c;
      issue_d.id  = grant_c ? ID_W'(gnt_idx_c) : '0;
      if (grant_c) begin
        mul_a_d = sel_a_c;
        mul_b_d = sel_b_c;
`ifdef MULT_SCHED_FIXED_PRIO_EN
`else
        rr_d    = (gnt_idx_c == IDW'(N_REQ - 1)) ? '0 : gnt_idx_c + IDW'(1);
`endif
      end
      rsp_valid_d = tag_out.vld ? (N_REQ'(1) << tag_out.id) : '0;
      if (tag_out.vld) rsp_data_d = mul_product;
      // Count of valid tags inside the tag pipe.
      inflight_d = inflight_q + CNT_W'(issue_q.vld) - CNT_W'(tag_out.vld);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      issue_q     <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      inflight_q  <= '0;
`ifdef MULT_SCHED_FIXED_PRIO_EN
`else
      rr_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      issue_q     <= issue_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      inflight_q  <= inflight_d;
`ifdef MULT_SCHED_FIXED_PRIO_EN
`else
      rr_q        <= rr_d;
`endif
    end
  end

  mult_sched_tagpipe #(
    .DEPTH (TDEPTH),
    .W     ($bits(tag_t))
  ) u_tagpipe (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .d   (issue_q),
    .q   (tag_out)
  );

  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign mul_ena    = ena;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign busy       = issue_q.vld || (inflight_q != '0);
  assign flush_done = (state_q == DRAIN) && flush && !busy;

endmodule

// File: tb/tb_mult_sched.sv
// Testbench for mult_sched: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_mult_sched;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned LAT   = 2;

  logic        clk = 1'b0;
  logic        rst, ena, flush;
  logic [3:0]  req_valid, req_ready, rsp_valid;
  logic [15:0] req_a, req_b;
  logic        flush_done, mul_ena, busy;
  logic [3:0]  mul_a, mul_b;
  logic [7:0]  mul_product, rsp_data;

  always #5 clk = ~clk;

  mult_sched #(.N_REQ(N_REQ), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .flush(flush), .flush_done(flush_done),
    .mul_a(mul_a), .mul_b(mul_b), .mul_ena(mul_ena), .mul_product(mul_product),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  // Behavioural multiplier: captures operands, then LAT pipeline stages.
  logic [7:0] mp [LAT+1];
  always @(posedge clk) begin
    if (mul_ena) begin
      mp[0] <= 8'(mul_a) * 8'(mul_b);
      for (int i = 1; i <= LAT; i++) mp[i] <= mp[i-1];
    end
  end
  assign mul_product = mp[LAT];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: ops are due LAT+2 enabled edges after acceptance.
  typedef struct { int id; int data; longint due; } op_t;
  op_t        m_q[$];
  int         m_rr;
  bit         m_drain;
  longint     m_tick = 0;
  logic [3:0] e_rsp_valid;
  logic [7:0] e_rsp_data;
  logic [3:0] e_mul_a, e_mul_b;
  int         e_gnt;

  function automatic int pick();
    int start;
    if (rst || !ena || flush || m_drain) return -1;
`ifdef MULT_SCHED_FIXED_PRIO_EN
    start = 0;
`else
    start = m_rr;
`endif
    for (int k = 0; k < N_REQ; k++) begin
      int i;
      i = (start + k) % N_REQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit m_busy();
    foreach (m_q[i]) if (m_q[i].due > m_tick) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_rr = 0; m_drain = 1'b0;
    e_rsp_valid = '0; e_rsp_data = '0; e_mul_a = '0; e_mul_b = '0;
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    op_t o;
    @(negedge clk);
    e_gnt = pick();
    check("req_ready",  req_ready,  (e_gnt < 0) ? 0 : (1 << e_gnt));
    check("rsp_valid",  rsp_valid,  e_rsp_valid);
    check("rsp_data",   rsp_data,   e_rsp_data);
    check("busy",       busy,       m_busy());
    check("flush_done", flush_done, m_drain && flush && !m_busy());
    check("mul_a",      mul_a,      e_mul_a);
    check("mul_b",      mul_b,      e_mul_b);
    check("mul_ena",    mul_ena,    ena);
    @(posedge clk);
    if (rst) begin
      m_reset();
    end else if (ena) begin
      m_tick++;
      if (e_gnt >= 0) begin
        o.id   = e_gnt;
        o.data = req_a[4*e_gnt +: 4] * req_b[4*e_gnt +: 4];
        o.due  = m_tick + LAT + 2;
        m_q.push_back(o);
        e_mul_a = req_a[4*e_gnt +: 4];
        e_mul_b = req_b[4*e_gnt +: 4];
        m_rr    = (e_gnt + 1) % N_REQ;
      end
      m_drain     = flush;
      e_rsp_valid = '0;
      foreach (m_q[i]) begin
        if (m_q[i].due == m_tick) begin
          e_rsp_valid = 4'(1 << m_q[i].id);
          e_rsp_data  = 8'(m_q[i].data);
        end
      end
      while (m_q.size() > 0 && m_q[0].due < m_tick) void'(m_q.pop_front());
    end
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_a[4*i +: 4] = 4'(a);
    req_b[4*i +: 4] = 4'(b);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; flush = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0;
    repeat (2) @(posedge clk);
    m_reset();
    #1;
    rst = 1'b0;
    check("rst_rsp_valid",  rsp_valid,  0);
    check("rst_rsp_data",   rsp_data,   0);
    check("rst_busy",       busy,       0);
    check("rst_flush_done", flush_done, 0);
    check("rst_mul_a",      mul_a,      0);

    // Lone request: 3*5 from requester 0.
    req_valid = 4'b0001; set_op(0, 3, 5);
    step();
    req_valid = '0;
    repeat (4) step();
    check("t1_rsp_valid", rsp_valid, 4'b0001);
    check("t1_rsp_data",  rsp_data,  15);
    repeat (2) step();

    // All requesters continuously valid.
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 4; i++) set_op(i, $urandom_range(0, 15), $urandom_range(0, 15));
      step();
    end
    req_valid = '0;
    repeat (6) step();

    // Full-width product.
    req_valid = 4'b0100; set_op(2, 15, 15);
    step();
    req_valid = '0;
    repeat (4) step();
    check("t3_rsp_valid", rsp_valid, 4'b0100);
    check("t3_rsp_data",  rsp_data,  225);
    repeat (2) step();

    // Flush with four ops in flight; requests stay valid throughout.
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_op(i, i + 2, i + 9);
    repeat (4) step();
    flush = 1'b1;
    repeat (8) step();
    check("t4_flush_done", flush_done, 1);
    check("t4_busy",       busy,       0);
    flush = 1'b0; req_valid = '0;
    repeat (2) step();

    // Enable low for three cycles with an op in flight.
    req_valid = 4'b0010; set_op(1, 7, 9);
    step();
    req_valid = '0;
    step();
    ena = 1'b0;
    repeat (3) step();
    ena = 1'b1;
    repeat (2) step();
    check("t5_not_yet", rsp_valid, 0);
    step();
    check("t5_rsp_valid", rsp_valid, 4'b0010);
    check("t5_rsp_data",  rsp_data,  63);
    repeat (2) step();

    // Reset with two ops in flight.
    req_valid = 4'b0011; set_op(0, 4, 4); set_op(1, 5, 5);
    repeat (2) step();
    req_valid = '0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rsp_valid", rsp_valid, 0);
    check("t6_busy",      busy,      0);
    check("t6_mul_a",     mul_a,     0);
    req_valid = 4'b1010; set_op(1, 2, 3); set_op(3, 6, 6);
    #1;
    check("t6_grant", req_ready, 4'b0010);
    step();
    req_valid = '0;
    repeat (6) step();

    // Requesters 0 and 3 continuously valid.
    req_valid = 4'b1001; set_op(0, 1, 11); set_op(3, 13, 2);
    repeat (6) step();
    req_valid = '0;
    repeat (6) step();

    // Randomized traffic with occasional ena, flush and reset activity.
    for (int c = 0; c < 600; c++) begin
      req_valid = 4'($urandom);
      req_a     = 16'($urandom);
      req_b     = 16'($urandom);
      ena       = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) flush = ~flush;
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; ena = 1'b1; flush = 1'b0; req_valid = '0;
    repeat (8) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
